// File: rtl/hilo_if.sv
// HILO write-pipeline bus between the EX/MEM control and the HILO unit.
interface hilo_if #(
  parameter int unsigned HALF_W = 32
);
  localparam int unsigned HILO_W = 2 * HALF_W;

  logic              ex_valid;
  logic              ex_wr_hi;
  logic              ex_wr_lo;
  logic [HILO_W-1:0] ex_hilo;
  logic              ex_md_busy;
  logic              stall_m;
  logic              flush_m;
  logic [HILO_W-1:0] hilo_fwd;
  logic [HILO_W-1:0] hilo_arch;
  logic              m_pending;

  modport master (
    output ex_valid, ex_wr_hi, ex_wr_lo, ex_hilo, ex_md_busy, stall_m, flush_m,
    input  hilo_fwd, hilo_arch, m_pending
  );

  modport slave (
    input  ex_valid, ex_wr_hi, ex_wr_lo, ex_hilo, ex_md_busy, stall_m, flush_m,
    output hilo_fwd, hilo_arch, m_pending
  );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO register file with MEM and WB staging and per-half forwarding.
module hilo_unit #(
  parameter int unsigned HALF_W = 32
) (
  input  logic    clk,
  input  logic    rst,
  hilo_if.slave   bus
);
  localparam int unsigned HILO_W = 2 * HALF_W;

  logic              r_m_valid;
  logic              r_m_wr_hi;
  logic              r_m_wr_lo;
  logic [HILO_W-1:0] r_m_data;
  logic              r_w_valid;
  logic              r_w_wr_hi;
  logic              r_w_wr_lo;
  logic [HILO_W-1:0] r_w_data;
  logic [HALF_W-1:0] r_arch_hi;
  logic [HALF_W-1:0] r_arch_lo;

  logic              w_capture;
  logic [HALF_W-1:0] w_fwd_hi;
  logic [HALF_W-1:0] w_fwd_lo;

  assign w_capture = bus.ex_valid & ~bus.ex_md_busy & (bus.ex_wr_hi | bus.ex_wr_lo);

  // Pipeline levels; flush kills only M, and either stall or flush feeds W a bubble.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_m_valid <= 1'b0;
      r_w_valid <= 1'b0;
      r_arch_hi <= '0;
      r_arch_lo <= '0;
    end else begin
      if (bus.flush_m) begin
        r_m_valid <= 1'b0;
      end else if (!bus.stall_m) begin
        r_m_valid <= w_capture;
        r_m_wr_hi <= bus.ex_wr_hi;
        r_m_wr_lo <= bus.ex_wr_lo;
        r_m_data  <= bus.ex_hilo;
      end

      if (bus.stall_m || bus.flush_m) begin
        r_w_valid <= 1'b0;
      end else begin
        r_w_valid <= r_m_valid;
        r_w_wr_hi <= r_m_wr_hi;
        r_w_wr_lo <= r_m_wr_lo;
        r_w_data  <= r_m_data;
      end

      if (r_w_valid && r_w_wr_hi) r_arch_hi <= r_w_data[HILO_W-1:HALF_W];
      if (r_w_valid && r_w_wr_lo) r_arch_lo <= r_w_data[HALF_W-1:0];
    end
  end

  // Youngest valid writer of each half wins.
  always_comb begin
    w_fwd_hi = r_arch_hi;
    w_fwd_lo = r_arch_lo;
    if (r_m_valid && r_m_wr_hi)      w_fwd_hi = r_m_data[HILO_W-1:HALF_W];
    else if (r_w_valid && r_w_wr_hi) w_fwd_hi = r_w_data[HILO_W-1:HALF_W];
    if (r_m_valid && r_m_wr_lo)      w_fwd_lo = r_m_data[HALF_W-1:0];
    else if (r_w_valid && r_w_wr_lo) w_fwd_lo = r_w_data[HALF_W-1:0];
  end

  assign bus.hilo_fwd  = {w_fwd_hi, w_fwd_lo};
  assign bus.hilo_arch = {r_arch_hi, r_arch_lo};
  assign bus.m_pending = r_m_valid | r_w_valid;
endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit: directed scenarios followed by random traffic.
module tb_hilo_unit;
  localparam int unsigned HALF_W = 32;
  localparam int unsigned HILO_W = 2 * HALF_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hilo_if #(.HALF_W(HALF_W)) bus ();
  hilo_unit #(.HALF_W(HALF_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [HILO_W-1:0] fwd;
    logic [HILO_W-1:0] arch;
    logic              pend;
  } exp_t;

  typedef struct {
    int                age;
    logic              hi;
    logic              lo;
    logic [HILO_W-1:0] d;
  } wr_t;

  exp_t              exp_q[$];
  wr_t               pend_q[$];
  logic [HALF_W-1:0] m_hi = '0;
  logic [HALF_W-1:0] m_lo = '0;
  int                checks = 0;
  int                errors = 0;

  // Reference: in-flight writes in program order with age (0 = MEM, 1 = WB).
  task automatic model_step();
    wr_t  nq[$];
    wr_t  e;
    exp_t x;
    logic [HALF_W-1:0] fh, fl;
    if (!rst) begin
      pend_q.delete();
      m_hi = '0;
      m_lo = '0;
    end else begin
      foreach (pend_q[i]) begin
        e = pend_q[i];
        if (e.age == 1) begin
          if (e.hi) m_hi = e.d[HILO_W-1:HALF_W];
          if (e.lo) m_lo = e.d[HALF_W-1:0];
        end else if (!bus.flush_m) begin
          if (!bus.stall_m) e.age = 1;
          nq.push_back(e);
        end
      end
      if (!bus.stall_m && !bus.flush_m && bus.ex_valid && !bus.ex_md_busy &&
          (bus.ex_wr_hi || bus.ex_wr_lo)) begin
        e.age = 0;
        e.hi  = bus.ex_wr_hi;
        e.lo  = bus.ex_wr_lo;
        e.d   = bus.ex_hilo;
        nq.push_back(e);
      end
      pend_q = nq;
    end
    fh = m_hi;
    fl = m_lo;
    foreach (pend_q[i]) begin
      if (pend_q[i].hi) fh = pend_q[i].d[HILO_W-1:HALF_W];
      if (pend_q[i].lo) fl = pend_q[i].d[HALF_W-1:0];
    end
    x.fwd  = {fh, fl};
    x.arch = {m_hi, m_lo};
    x.pend = (pend_q.size() > 0);
    exp_q.push_back(x);
  endtask

  task automatic drive(input logic rv, input logic v, input logic hi, input logic lo,
                       input logic [HILO_W-1:0] d, input logic busy,
                       input logic st, input logic fl);
    @(negedge clk);
    #1;
    rst            = rv;
    bus.ex_valid   = v;
    bus.ex_wr_hi   = hi;
    bus.ex_wr_lo   = lo;
    bus.ex_hilo    = d;
    bus.ex_md_busy = busy;
    bus.stall_m    = st;
    bus.flush_m    = fl;
    model_step();
  endtask

  function automatic logic [HILO_W-1:0] rnd();
    return HILO_W'({$urandom(), $urandom()});
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b1, 1'b1, rnd(), 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: one expected snapshot per clock edge, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks = checks + 3;
      if (bus.hilo_fwd !== e.fwd) begin
        errors = errors + 1;
        $display("FAIL hilo_fwd t=%0t got=%h want=%h", $time, bus.hilo_fwd, e.fwd);
      end
      if (bus.hilo_arch !== e.arch) begin
        errors = errors + 1;
        $display("FAIL hilo_arch t=%0t got=%h want=%h", $time, bus.hilo_arch, e.arch);
      end
      if (bus.m_pending !== e.pend) begin
        errors = errors + 1;
        $display("FAIL m_pending t=%0t got=%b want=%b", $time, bus.m_pending, e.pend);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [HILO_W-1:0] d;
    int drain;
    bus.ex_valid   = 1'b0;
    bus.ex_wr_hi   = 1'b0;
    bus.ex_wr_lo   = 1'b0;
    bus.ex_hilo    = '0;
    bus.ex_md_busy = 1'b0;
    bus.stall_m    = 1'b0;
    bus.flush_m    = 1'b0;

    // Reset, with a write offered that must be ignored.
    drive(1'b0, 1'b1, 1'b1, 1'b1, rnd(), 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, rnd(), 1'b0, 1'b0, 1'b0);
    idle(2);

    // MULT commit.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 64'h00000001_FFFFFFFE, 1'b0, 1'b0, 1'b0);
    idle(3);

    // MTHI then MTLO.
    d = rnd();
    drive(1'b1, 1'b1, 1'b1, 1'b0, {32'hAAAA5555, d[HALF_W-1:0]}, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, {d[HILO_W-1:HALF_W], 32'h12345678}, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Flush together with stall while another write is offered.
    drive(1'b1, 1'b1, 1'b1, 1'b1, rnd(), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, rnd(), 1'b0, 1'b1, 1'b1);
    idle(3);

    // Stall for three cycles, then release.
    drive(1'b1, 1'b1, 1'b0, 1'b1, rnd(), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 1'b1, rnd(), 1'b0, 1'b1, 1'b0);
    idle(4);

    // Multiply/divide busy gating.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b1, 1'b1, rnd(), 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, rnd(), 1'b0, 1'b0, 1'b0);
    idle(3);

    // Reset on the commit edge of an in-flight write.
    drive(1'b1, 1'b1, 1'b1, 1'b1, rnd(), 1'b0, 1'b0, 1'b0);
    idle(1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, rnd(), 1'b0, 1'b0, 1'b0);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 49) != 0),
            ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            rnd(),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 7) == 0));
    end
    idle(2);

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    #1;
    if (exp_q.size() > 0) begin
      errors = errors + 1;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
